// File: rtl/lr35902_dbg_bpctl.sv
// PC breakpoint controller for the LR35902 debug unit: nibble-programmed
// breakpoint bank with ignore counts, registered halt request and resume-skip.
module lr35902_dbg_bpctl #(
    parameter  int NUM_BP = 4,
    parameter  int CNT_W  = 4,
    localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             fetch,
    input  logic             step,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_bp,
    input  logic [1:0]       cfg_field,
    input  logic [3:0]       cfg_nib,
    input  logic             resume,
    output logic             halt_req,
    output logic [IDX_W-1:0] hit_id
);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        HIT   = 2'd1,
        SKIP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      addr_q [NUM_BP];
    logic [15:0]      addr_d [NUM_BP];
    logic             en_q   [NUM_BP];
    logic             en_d   [NUM_BP];
    logic [CNT_W-1:0] cnt_q  [NUM_BP];
    logic [CNT_W-1:0] cnt_d  [NUM_BP];
    logic [15:0]      skip_pc_q, skip_pc_d;
    logic             halt_req_q, halt_req_d;
    logic [IDX_W-1:0] hit_id_q, hit_id_d;

    logic [NUM_BP-1:0] match;
    logic              any_match;
    logic [IDX_W-1:0]  win;
    logic              eval;

    always_comb begin
        state_d    = state_q;
        skip_pc_d  = skip_pc_q;
        halt_req_d = halt_req_q;
        hit_id_d   = hit_id_q;
        for (int i = 0; i < NUM_BP; i++) begin
            addr_d[i] = addr_q[i];
            en_d[i]   = en_q[i];
            cnt_d[i]  = cnt_q[i];
        end

        match = '0;
        for (int i = 0; i < NUM_BP; i++)
            match[i] = fetch & ~step & en_q[i] & (pc == addr_q[i]);
        any_match = |match;

        // Descending scan so the lowest matching index is the one left in win.
        win = '0;
        for (int i = NUM_BP - 1; i >= 0; i--)
            if (match[i]) win = IDX_W'(i);

        eval = (state_q == ARMED) ||
               ((state_q == SKIP) && fetch && (pc != skip_pc_q));

        if (state_q == HIT) begin
            if (resume) begin
                state_d    = SKIP;
                halt_req_d = 1'b0;
            end
        end else if (eval) begin
            state_d = ARMED;
            if (any_match) begin
                if (cnt_q[win] != '0) begin
                    cnt_d[win] = cnt_q[win] - CNT_W'(1);
                end else begin
                    state_d    = HIT;
                    halt_req_d = 1'b1;
                    hit_id_d   = win;
                    skip_pc_d  = pc;
                end
            end
        end

        // Applied last so a same-cycle count write overrides the decrement.
        if (cfg_we && (32'(cfg_bp) < NUM_BP)) begin
            case (cfg_field)
                2'd0:    addr_d[cfg_bp] = {cfg_nib, addr_q[cfg_bp][15:4]};
                2'd1:    en_d[cfg_bp]   = cfg_nib[0];
                2'd2:    cnt_d[cfg_bp]  = cfg_nib[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q    <= ARMED;
            skip_pc_q  <= '0;
            halt_req_q <= 1'b0;
            hit_id_q   <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= 16'hFFFF;
                en_q[i]   <= 1'b0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            skip_pc_q  <= skip_pc_d;
            halt_req_q <= halt_req_d;
            hit_id_q   <= hit_id_d;
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= addr_d[i];
                en_q[i]   <= en_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign halt_req = halt_req_q;
    assign hit_id   = hit_id_q;

endmodule

// File: tb/tb_lr35902_dbg_bpctl.sv
// Scoreboard bench for lr35902_dbg_bpctl: each driven cycle queues the
// expected post-edge outputs, a monitor pops and compares after the edge.
module tb_lr35902_dbg_bpctl;

    logic        cpu_clk;
    logic        reset;
    logic [15:0] pc;
    logic        fetch;
    logic        step;
    logic        cfg_we;
    logic [1:0]  cfg_bp;
    logic [1:0]  cfg_field;
    logic [3:0]  cfg_nib;
    logic        resume;
    logic        halt_req;
    logic [1:0]  hit_id;

    typedef struct {
        logic       halt;
        logic [1:0] id;
        int         step_no;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   step_no = 0;

    lr35902_dbg_bpctl #(.NUM_BP(4), .CNT_W(4)) dut (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .pc       (pc),
        .fetch    (fetch),
        .step     (step),
        .cfg_we   (cfg_we),
        .cfg_bp   (cfg_bp),
        .cfg_field(cfg_field),
        .cfg_nib  (cfg_nib),
        .resume   (resume),
        .halt_req (halt_req),
        .hit_id   (hit_id)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // hit_id is only meaningful while halt_req is expected high, or right after reset.
    always @(posedge cpu_clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("halt_req@%0d", e.step_no), int'(halt_req), int'(e.halt));
            if (e.halt)
                check($sformatf("hit_id@%0d", e.step_no), int'(hit_id), int'(e.id));
        end
    end

    task automatic drive(input logic f, input logic [15:0] p, input logic s,
                         input logic r, input logic we, input logic [1:0] bp,
                         input logic [1:0] fld, input logic [3:0] nib,
                         input logic eh, input logic [1:0] eid);
        exp_t e;
        @(negedge cpu_clk);
        reset     = 1'b0;
        fetch     = f;
        pc        = p;
        step      = s;
        resume    = r;
        cfg_we    = we;
        cfg_bp    = bp;
        cfg_field = fld;
        cfg_nib   = nib;
        step_no++;
        e.halt    = eh;
        e.id      = eid;
        e.step_no = step_no;
        sbq.push_back(e);
    endtask

    task automatic fe(input logic [15:0] p, input logic eh, input logic [1:0] eid);
        drive(1'b1, p, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 4'd0, eh, eid);
    endtask

    task automatic wr(input logic [1:0] bp, input logic [1:0] fld, input logic [3:0] nib,
                      input logic eh, input logic [1:0] eid);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, bp, fld, nib, eh, eid);
    endtask

    task automatic res();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 4'd0, 1'b0, 2'd0);
    endtask

    task automatic set_addr(input logic [1:0] bp, input logic [15:0] a);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] nib;
            nib = a[k*4 +: 4];
            wr(bp, 2'd0, nib, 1'b0, 2'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        reset  = 1'b1;
        fetch  = 1'b0;
        cfg_we = 1'b0;
        resume = 1'b0;
        step   = 1'b0;
        @(posedge cpu_clk);
        #1;
        check("reset_halt", int'(halt_req), 0);
        check("reset_hit_id", int'(hit_id), 0);
    endtask

    initial begin
        reset = 1'b1; pc = '0; fetch = 0; step = 0; cfg_we = 0;
        cfg_bp = '0; cfg_field = 2'd3; cfg_nib = '0; resume = 0;

        // Basic hit, resume skip, re-arm after moving on
        do_reset();
        set_addr(2'd2, 16'h1234);
        wr(2'd2, 2'd1, 4'd1, 1'b0, 2'd0);
        fe(16'h1234, 1'b1, 2'd2);
        fe(16'h1234, 1'b1, 2'd2);
        res();
        fe(16'h1234, 1'b0, 2'd0);
        fe(16'h1234, 1'b0, 2'd0);
        fe(16'h1235, 1'b0, 2'd0);
        fe(16'h1234, 1'b1, 2'd2);
        res();

        // Ignore count 2, then a consumed count stays at 0
        do_reset();
        set_addr(2'd0, 16'h0100);
        wr(2'd0, 2'd1, 4'd1, 1'b0, 2'd0);
        wr(2'd0, 2'd2, 4'd2, 1'b0, 2'd0);
        fe(16'h0100, 1'b0, 2'd0);
        fe(16'h0100, 1'b0, 2'd0);
        fe(16'h0100, 1'b1, 2'd0);
        res();
        fe(16'h0200, 1'b0, 2'd0);
        fe(16'h0100, 1'b1, 2'd0);
        res();

        // Priority: bp1 beats bp3; only bp1's count is touched
        do_reset();
        set_addr(2'd1, 16'h0040);
        set_addr(2'd3, 16'h0040);
        wr(2'd1, 2'd1, 4'd1, 1'b0, 2'd0);
        wr(2'd3, 2'd1, 4'd1, 1'b0, 2'd0);
        fe(16'h0040, 1'b1, 2'd1);
        res();
        fe(16'h0000, 1'b0, 2'd0);
        wr(2'd1, 2'd2, 4'd1, 1'b0, 2'd0);
        fe(16'h0040, 1'b0, 2'd0);
        fe(16'h0040, 1'b1, 2'd1);
        res();

        // Suppression: reset default address, step, disabled breakpoint
        do_reset();
        fe(16'hFFFF, 1'b0, 2'd0);
        set_addr(2'd0, 16'h0500);
        wr(2'd0, 2'd1, 4'd1, 1'b0, 2'd0);
        drive(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 4'd0, 1'b0, 2'd0);
        wr(2'd0, 2'd1, 4'd0, 1'b0, 2'd0);
        fe(16'h0500, 1'b0, 2'd0);
        wr(2'd0, 2'd1, 4'd1, 1'b0, 2'd0);
        fe(16'h0500, 1'b1, 2'd0);
        res();

        // Collision: count write of 5 beats the decrement of count 1
        do_reset();
        set_addr(2'd0, 16'h0700);
        wr(2'd0, 2'd1, 4'd1, 1'b0, 2'd0);
        wr(2'd0, 2'd2, 4'd1, 1'b0, 2'd0);
        drive(1'b1, 16'h0700, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 4'd5, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) fe(16'h0700, 1'b0, 2'd0);
        fe(16'h0700, 1'b1, 2'd0);
        res();

        // Reset during HIT; disabling the hit bp does not drop halt_req
        do_reset();
        set_addr(2'd2, 16'h1234);
        wr(2'd2, 2'd1, 4'd1, 1'b0, 2'd0);
        fe(16'h1234, 1'b1, 2'd2);
        wr(2'd2, 2'd1, 4'd0, 1'b1, 2'd2);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 4'd0, 1'b1, 2'd2);
        do_reset();
        fe(16'h1234, 1'b0, 2'd0);
        fe(16'h1234, 1'b0, 2'd0);

        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 4'd0, 1'b0, 2'd0);
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge cpu_clk);
        #2;
        if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lr35902_dbg_bpctl.md
# lr35902_dbg_bpctl

Breakpoint controller for the LR35902 debug unit, in the `cpu_clk` domain. It holds a bank of PC breakpoints that the debug command decoder programs nibble by nibble. Each breakpoint has an enable and an ignore count. The block compares the PC on each opcode fetch and raises a registered halt request on a hit. After the debugger resumes, it suppresses re-triggering on the same PC until execution moves on.

## Interface

Parameters:
- `NUM_BP`, default 4: number of breakpoints; `hit_id` and `cfg_bp` width is `clog2(NUM_BP)`.
- `CNT_W`, default 4: ignore-count width; must be ≤ 4.

Ports:
- `cpu_clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high; clock `cpu_clk`.
- `pc`  in  16: current program counter.
- `fetch`  in  1: one-cycle strobe, high when the CPU fetches the opcode at `pc`.
- `step`  in  1: high while single-stepping; suppresses all matching.
- `cfg_we`  in  1: configuration write strobe.
- `cfg_bp`  in  2: breakpoint index being written.
- `cfg_field`  in  2: field select. 0 = address nibble, 1 = enable, 2 = ignore count, 3 = no-op.
- `cfg_nib`  in  4: write data.
- `resume`  in  1: one-cycle pulse that releases a hit.
- `halt_req`  out  1: registered halt request to the CPU.
- `hit_id`  out  2: index of the last breakpoint that hit; valid while `halt_req` = 1.

## Operation

- **Reset values**
  - All addresses 16'hFFFF; all enables 0; all counts 0.
  - State ARMED; `halt_req` = 0; `hit_id` = 0.
  - Reset mid-HIT or mid-SKIP returns to ARMED with `halt_req` = 0 on the next edge.
- **Address write** (`cfg_field` 0): `addr[bp] <= {cfg_nib, addr[bp][15:4]}`. Four writes, low nibble first, load a full address.
- **Enable write** (`cfg_field` 1): `en[bp] <= cfg_nib[0]`.
- **Count write** (`cfg_field` 2): `cnt[bp] <= cfg_nib[CNT_W-1:0]`.
- Config writes are accepted in every state.
- **Match condition:** `fetch & !step & en[i] & (pc == addr[i])`.
  - When several breakpoints match, the lowest index wins.
  - Only the winning breakpoint's counter is touched.
- **FSM**
  - ARMED, match, `cnt[w] != 0`: `cnt[w]` decrements by 1 (no wrap, since it is non-zero); stay in ARMED.
  - ARMED, match, `cnt[w] == 0`: go to HIT; set `halt_req` = 1, `hit_id` = w, `skip_pc` = `pc`.
  - HIT: `halt_req` holds at 1; further matches are ignored. On `resume`: go to SKIP, `halt_req` = 0.
  - SKIP, `fetch` with `pc == skip_pc`: no match evaluated.
  - SKIP, `fetch` with `pc != skip_pc`: that same fetch is evaluated exactly as in ARMED, and the state goes to ARMED or HIT.
  - `resume` in ARMED or SKIP is ignored.
- **Simultaneous events**
  - Match evaluation uses pre-write register values.
  - A count write to the winning index takes priority over the decrement.
  - Disabling the hit breakpoint during HIT does not drop `halt_req`; only `resume` or `reset` does.
- A count that is not re-armed stays 0 after being consumed.

## Timing

- `halt_req` rises on the edge after the matching `fetch` cycle, giving 1-cycle latency; `hit_id` updates on the same edge.
- `halt_req` falls on the edge after the `resume` cycle.
- Config writes take effect on the next edge and apply to a `fetch` one cycle later.
- There is no combinational path from inputs to outputs.

## Test plan

1. **Basic hit:** reset; write nibbles 4,3,2,1 to bp2 (addr 16'h1234); enable bp2; `fetch` at pc 16'h1234 → `halt_req` = 1 next cycle, `hit_id` = 2. `resume` → `halt_req` = 0 next cycle. Repeated `fetch` at 16'h1234 gives no halt. `fetch` at 16'h1235 gives no halt. `fetch` at 16'h1234 again → halt.
2. **Ignore count:** bp0 = 16'h0100, enabled, count 2 → first two fetches at 16'h0100 do not halt and the count drops 2 → 1 → 0; the third fetch halts with `hit_id` = 0.
3. **Priority:** bp1 and bp3 both = 16'h0040, both enabled → `hit_id` = 1. Set bp1 count 1 → first fetch decrements bp1 only with no halt; second fetch halts with `hit_id` = 1.
4. **Suppression:** `step` = 1 during a matching `fetch` → no halt. A disabled matching breakpoint → no halt. Reset-default address 16'hFFFF with enable 0 and `fetch` at 16'hFFFF → no halt.
5. **Collision:** a count write of 5 to bp0 in the same cycle as a bp0 match with count 1 → no halt, count = 5.
6. **Reset:** assert `reset` during HIT → `halt_req` = 0 and ARMED next cycle. An old breakpoint at pc 16'h1234 no longer fires, because address resets to 16'hFFFF and enable to 0.
